alu_seq: RTL and testbench

- Execute stage directly downstream of the 8x8 register file.
- Consumes the two register read operands and a 3-bit operation select, and computes an 8-bit result. Single-cycle ops finish in one cycle; multi-cycle ops (shift-add multiply, iterative shift) take several.
- Presents the result with a one-cycle write strobe and the latched destination address. These feed the register file's write data, write enable and write address directly.

---
 rtl/alu_seq_if.sv | 28 ++
 rtl/alu_seq.sv | 163 ++++++++++++++++
 tb/tb_alu_seq.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/alu_seq_if.sv
// Execute-stage bundle between operand source and ALU; results feed the register file write port.
// master drives requests and operands, slave returns registered result, strobe and status.
interface alu_seq_if #(
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 3
) ();
  logic              start;
  logic [2:0]        select;
  logic [WIDTH-1:0]  data1;
  logic [WIDTH-1:0]  data2;
  logic [ADDR_W-1:0] dest_in;
  logic [WIDTH-1:0]  result;
  logic [ADDR_W-1:0] dest_out;
  logic              write_en;
  logic              busy;
  logic              zero;
  logic              illegal;

  modport master (
    output start, select, data1, data2, dest_in,
    input  result, dest_out, write_en, busy, zero, illegal
  );

  modport slave (
    input  start, select, data1, data2, dest_in,
    output result, dest_out, write_en, busy, zero, illegal
  );
endinterface

// File: rtl/alu_seq.sv
// Sequential ALU: 1 cycle for simple ops, WIDTH+1 for MUL, amount+1 for SLL; one-cycle write strobe.
// No queueing: START is accepted only while idle (busy low) and is dropped otherwise.
module alu_seq #(
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 3
) (
  input logic      clk,
  input logic      reset,
  alu_seq_if.slave bus
);
  localparam int SH_W  = $clog2(WIDTH);
  localparam int CNT_W = $clog2(WIDTH + 1);

  localparam logic [2:0] OP_FWD = 3'b000;
  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_SUB = 3'b100;
  localparam logic [2:0] OP_MUL = 3'b101;
  localparam logic [2:0] OP_SLL = 3'b110;

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t            state_q, state_d;
  logic [2:0]        op_q, op_d;
  logic [WIDTH-1:0]  mcand_q, mcand_d;
  logic [WIDTH-1:0]  mplier_q, mplier_d;
  logic [WIDTH-1:0]  acc_q, acc_d;
  logic [WIDTH-1:0]  result_q, result_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] dest_q, dest_d;
  logic [ADDR_W-1:0] dest_out_q, dest_out_d;
  logic              we_q, we_d;
  logic              busy_q, busy_d;
  logic              zero_q, zero_d;
  logic              ill_q, ill_d;

  logic              fin;
  logic              fin_ill;
  logic [WIDTH-1:0]  fin_res;
  logic [ADDR_W-1:0] fin_dest;
  logic [WIDTH-1:0]  acc_step;
  logic [SH_W-1:0]   amt;

  assign amt      = bus.data2[SH_W-1:0];
  assign acc_step = mplier_q[0] ? acc_q + mcand_q : acc_q;

  // SLL reuses the multiplicand register as its shifting value.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    mcand_d    = mcand_q;
    mplier_d   = mplier_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    dest_d     = dest_q;
    result_d   = result_q;
    dest_out_d = dest_out_q;
    zero_d     = zero_q;
    fin        = 1'b0;
    fin_ill    = 1'b0;
    fin_res    = '0;
    fin_dest   = dest_q;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          op_d     = bus.select;
          dest_d   = bus.dest_in;
          mcand_d  = bus.data1;
          mplier_d = bus.data2;
          acc_d    = '0;
          cnt_d    = '0;
          fin_dest = bus.dest_in;
          case (bus.select)
            OP_FWD: begin fin = 1'b1; fin_res = bus.data2; end
            OP_ADD: begin fin = 1'b1; fin_res = bus.data1 + bus.data2; end
            OP_AND: begin fin = 1'b1; fin_res = bus.data1 & bus.data2; end
            OP_OR:  begin fin = 1'b1; fin_res = bus.data1 | bus.data2; end
            OP_SUB: begin fin = 1'b1; fin_res = bus.data1 - bus.data2; end
            OP_MUL: begin
              cnt_d   = CNT_W'(WIDTH);
              state_d = EXEC;
            end
            OP_SLL: begin
              if (amt == '0) begin
                fin     = 1'b1;
                fin_res = bus.data1;
              end else begin
                cnt_d   = CNT_W'(amt);
                state_d = EXEC;
              end
            end
            default: begin fin = 1'b1; fin_ill = 1'b1; end
          endcase
        end
      end
      EXEC: begin
        cnt_d   = cnt_q - CNT_W'(1);
        mcand_d = mcand_q << 1;
        if (op_q == OP_MUL) begin
          acc_d    = acc_step;
          mplier_d = mplier_q >> 1;
          fin_res  = acc_step;
        end else begin
          fin_res  = mcand_q << 1;
        end
        fin = (cnt_q == CNT_W'(1));
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    we_d  = fin;
    ill_d = fin & fin_ill;
    if (fin) begin
      state_d    = DONE;
      result_d   = fin_res;
      zero_d     = (fin_res == '0);
      dest_out_d = fin_dest;
    end
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      op_q       <= '0;
      mcand_q    <= '0;
      mplier_q   <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      dest_q     <= '0;
      result_q   <= '0;
      dest_out_q <= '0;
      we_q       <= 1'b0;
      busy_q     <= 1'b0;
      zero_q     <= 1'b0;
      ill_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      mcand_q    <= mcand_d;
      mplier_q   <= mplier_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      dest_q     <= dest_d;
      result_q   <= result_d;
      dest_out_q <= dest_out_d;
      we_q       <= we_d;
      busy_q     <= busy_d;
      zero_q     <= zero_d;
      ill_q      <= ill_d;
    end
  end

  assign bus.result   = result_q;
  assign bus.dest_out = dest_out_q;
  assign bus.write_en = we_q;
  assign bus.busy     = busy_q;
  assign bus.zero     = zero_q;
  assign bus.illegal  = ill_q;
endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: directed and random ops compared against an arithmetic reference model.
module tb_alu_seq;
  localparam int WIDTH  = 8;
  localparam int ADDR_W = 3;

  logic clk;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  alu_seq_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) bus ();

  alu_seq #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int model_res(input int sel, input int a, input int b);
    case (sel)
      0:       return b;
      1:       return (a + b) % 256;
      2:       return a & b;
      3:       return a | b;
      4:       return (a - b + 256) % 256;
      5:       return (a * b) % 256;
      6:       return (a << (b % WIDTH)) % 256;
      default: return 0;
    endcase
  endfunction

  function automatic int model_lat(input int sel, input int b);
    if (sel == 5) return WIDTH + 1;
    if (sel == 6) return (b % WIDTH) + 1;
    return 1;
  endfunction

  task automatic wait_idle();
    for (int w = 0; w < 40 && bus.busy; w++) @(negedge clk);
    chk("idle_wait", {31'd0, bus.busy}, 32'd0);
  endtask

  task automatic run_op(input int sel, input int a, input int b, input int dst, input bit inject);
    int lat, exp, first, pulses;
    logic [7:0] r;
    logic [2:0] d;
    logic z, il;
    bit busy_bad, ill_bad;
    lat = model_lat(sel, b);
    exp = model_res(sel, a, b);
    wait_idle();
    @(negedge clk);
    bus.start   = 1'b1;
    bus.select  = sel[2:0];
    bus.data1   = a[7:0];
    bus.data2   = b[7:0];
    bus.dest_in = dst[2:0];
    @(posedge clk); #1;
    bus.start   = 1'b0;
    bus.select  = 3'($urandom);
    bus.data1   = 8'($urandom);
    bus.data2   = 8'($urandom);
    bus.dest_in = 3'($urandom);
    first = 0; pulses = 0; busy_bad = 0; ill_bad = 0;
    r = '0; d = '0; z = 1'b0; il = 1'b0;
    for (int k = 1; k <= WIDTH + 4; k++) begin
      if (bus.write_en) begin
        pulses++;
        if (first == 0) first = k;
        r = bus.result; d = bus.dest_out; z = bus.zero; il = bus.illegal;
      end else if (bus.illegal) begin
        ill_bad = 1;
      end
      if (k <= lat && !bus.busy) busy_bad = 1;
      if (inject && k == 3) begin
        bus.start  = 1'b1;
        bus.select = 3'b001;
        bus.data1  = 8'd3;
        bus.data2  = 8'd4;
      end
      if (inject && k == 4) bus.start = 1'b0;
      @(posedge clk); #1;
    end
    chk($sformatf("latency sel%0d", sel), first, lat);
    chk($sformatf("pulses sel%0d", sel), pulses, 1);
    chk($sformatf("result sel%0d a%0h b%0h", sel, a, b), {24'd0, r}, exp);
    chk($sformatf("dest sel%0d", sel), {29'd0, d}, dst);
    chk($sformatf("zero sel%0d", sel), {31'd0, z}, (exp == 0) ? 1 : 0);
    chk($sformatf("illegal sel%0d", sel), {31'd0, il}, (sel == 7) ? 1 : 0);
    chk($sformatf("busy sel%0d", sel), {31'd0, busy_bad}, 0);
    chk($sformatf("illegal_outside sel%0d", sel), {31'd0, ill_bad}, 0);
    chk($sformatf("hold sel%0d", sel), {24'd0, bus.result}, exp);
  endtask

  initial begin
    int pulses, sel, b;
    reset = 1'b0;
    bus.start = 1'b0; bus.select = '0; bus.data1 = '0; bus.data2 = '0; bus.dest_in = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_state", {bus.result, bus.dest_out, bus.write_en, bus.busy, bus.zero, bus.illegal}, 0);
    reset = 1'b1;

    run_op(1, 100, 27, 5, 0);
    run_op(1, 200, 100, 2, 0);
    run_op(4, 5, 7, 1, 0);
    run_op(5, 13, 11, 3, 0);
    run_op(5, 16, 16, 4, 0);
    run_op(5, 255, 255, 6, 0);
    run_op(6, 8'h81, 3, 7, 0);
    run_op(6, 8'h81, 0, 2, 0);
    run_op(5, 13, 11, 1, 1);

    // Start held high: only every second request can land.
    wait_idle();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      bus.start = 1'b1; bus.select = 3'b001;
      bus.data1 = 8'(10 * i); bus.data2 = 8'(i); bus.dest_in = 3'(i);
      @(posedge clk); #1;
      chk($sformatf("b2b_we%0d", i), {31'd0, bus.write_en}, (i % 2 == 0) ? 1 : 0);
      if (i % 2 == 0) chk($sformatf("b2b_res%0d", i), {24'd0, bus.result}, 11 * i);
    end
    bus.start = 1'b0;

    // Reset four cycles into a multiply must discard it.
    wait_idle();
    @(negedge clk);
    bus.start = 1'b1; bus.select = 3'b101; bus.data1 = 8'd13; bus.data2 = 8'd11; bus.dest_in = 3'd5;
    @(posedge clk); #1;
    bus.start = 1'b0;
    pulses = 0;
    for (int k = 1; k < 4; k++) begin
      if (bus.write_en) pulses++;
      @(posedge clk); #1;
    end
    reset = 1'b0;
    @(posedge clk); #1;
    chk("abort_outputs", {bus.result, bus.dest_out, bus.write_en, bus.busy, bus.zero, bus.illegal}, 0);
    reset = 1'b1;
    for (int k = 0; k < 15; k++) begin
      if (bus.write_en) pulses++;
      @(posedge clk); #1;
    end
    chk("abort_no_we", pulses, 0);
    run_op(1, 1, 1, 3, 0);

    run_op(7, 8'h12, 8'h34, 4, 0);
    run_op(0, 8'h33, 8'h5A, 6, 0);

    for (int n = 0; n < 40; n++) begin
      sel = $urandom_range(0, 7);
      b   = $urandom_range(0, 255);
      run_op(sel, $urandom_range(0, 255), b, $urandom_range(0, 7), (sel == 5) && ($urandom_range(0, 1) == 1));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
